// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide unit: HI/LO registers, fixed-latency busy sequencer and the
// MD stall request used by the hazard unit to hold a following MD instruction in D.
module e_mdu_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_Valid,
  input  logic [3:0]  E_MD_Op,
  input  logic [31:0] E_SrcA,
  input  logic [31:0] E_SrcB,
  input  logic        D_Is_MD,
  output logic [31:0] E_MD_Result,
  output logic        E_Busy,
  output logic        E_Start,
  output logic        MD_Stall
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMfhi  = 4'd7;
  localparam logic [3:0] OpMflo  = 4'd8;

  localparam logic [3:0] MulLoad = 4'(MUL_CYCLES);
  localparam logic [3:0] DivLoad = 4'(DIV_CYCLES);

  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_we_q, pend_we_d;

  logic        is_mul, is_div, is_signed_div;
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] div_num, div_den, den_safe;
  logic [31:0] quo_u, rem_u, quo, rem;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    is_mul        = (E_MD_Op == OpMult) || (E_MD_Op == OpMultu);
    is_div        = (E_MD_Op == OpDiv) || (E_MD_Op == OpDivu);
    is_signed_div = (E_MD_Op == OpDiv);
    E_Busy        = (cnt_q != 4'd0);
    E_Start       = E_Valid && (is_mul || is_div) && !E_Busy;
    MD_Stall      = D_Is_MD && (E_Start || E_Busy);
  end

  // Sign-extended 64-bit product truncated to 64 bits is the exact signed product.
  always_comb begin
    prod_s = {{32{E_SrcA[31]}}, E_SrcA} * {{32{E_SrcB[31]}}, E_SrcB};
    prod_u = {32'd0, E_SrcA} * {32'd0, E_SrcB};
  end

  // Signed divide via magnitudes; quotient truncates toward zero, remainder follows dividend.
  always_comb begin
    a_neg    = is_signed_div && E_SrcA[31];
    b_neg    = is_signed_div && E_SrcB[31];
    div_num  = a_neg ? (32'd0 - E_SrcA) : E_SrcA;
    div_den  = b_neg ? (32'd0 - E_SrcB) : E_SrcB;
    den_safe = (div_den == 32'd0) ? 32'd1 : div_den;
    quo_u    = div_num / den_safe;
    rem_u    = div_num % den_safe;
    quo      = (a_neg ^ b_neg) ? (32'd0 - quo_u) : quo_u;
    rem      = a_neg ? (32'd0 - rem_u) : rem_u;
  end

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    unique case (E_MD_Op)
      OpMult:         {res_hi, res_lo} = prod_s;
      OpMultu:        {res_hi, res_lo} = prod_u;
      OpDiv, OpDivu: begin
        res_hi = rem;
        res_lo = quo;
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    if (E_Start) begin
      cnt_d     = is_mul ? MulLoad : DivLoad;
      pend_hi_d = res_hi;
      pend_lo_d = res_lo;
      // A zero divisor still runs the full busy period but leaves HI/LO untouched.
      pend_we_d = is_mul || (E_SrcB != 32'd0);
    end else if (E_Busy) begin
      cnt_d = cnt_q - 4'd1;
      if ((cnt_q == 4'd1) && pend_we_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (E_Valid) begin
      if (E_MD_Op == OpMthi) hi_d = E_SrcA;
      if (E_MD_Op == OpMtlo) lo_d = E_SrcA;
    end
  end

  always_comb begin
    E_MD_Result = 32'd0;
    if (E_Valid && (E_MD_Op == OpMfhi)) E_MD_Result = hi_q;
    if (E_Valid && (E_MD_Op == OpMflo)) E_MD_Result = lo_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_we_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Directed self-checking bench for e_mdu_ctrl: reset, mult/div results, mthi/mfhi,
// stall generation, divide-by-zero, bubbles and mid-operation reset.
module tb_e_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_Valid;
  logic [3:0]  E_MD_Op;
  logic [31:0] E_SrcA;
  logic [31:0] E_SrcB;
  logic        D_Is_MD;
  logic [31:0] E_MD_Result;
  logic        E_Busy;
  logic        E_Start;
  logic        MD_Stall;

  int vectors = 0;
  int miscompares = 0;

  e_mdu_ctrl #(
    .MUL_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .E_Valid    (E_Valid),
    .E_MD_Op    (E_MD_Op),
    .E_SrcA     (E_SrcA),
    .E_SrcB     (E_SrcB),
    .D_Is_MD    (D_Is_MD),
    .E_MD_Result(E_MD_Result),
    .E_Busy     (E_Busy),
    .E_Start    (E_Start),
    .MD_Stall   (MD_Stall)
  );

  always #5 clk = ~clk;

  // The hazard unit must never let an MD op reach E while the unit is busy.
  always @(posedge clk) begin
    if (reset && E_Valid && E_Busy && (E_MD_Op >= 4'd1) && (E_MD_Op <= 4'd8)) begin
      miscompares++;
      $display("FAIL md_op_while_busy: op=%0d issued with E_Busy=1, required no MD op", E_MD_Op);
    end
  end

  // One E-stage cycle: inputs change on the falling edge, outputs are read 1ns later.
  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    E_Valid = v;
    E_MD_Op = op;
    E_SrcA  = a;
    E_SrcB  = b;
    #1;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    drive(1'b1, 4'd7, 32'd0, 32'd0);
    hi = E_MD_Result;
    drive(1'b1, 4'd8, 32'd0, 32'd0);
    lo = E_MD_Result;
  endtask

  task automatic test_reset;
    logic [31:0] hi, lo;
    reset = 1'b0; E_Valid = 1'b1; E_MD_Op = 4'd7; E_SrcA = '0; E_SrcB = '0; D_Is_MD = 1'b0;
    #1;
    vectors++;
    if (E_Busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %b want 0", E_Busy);
    end
    vectors++;
    if (E_MD_Result !== 32'd0) begin
      miscompares++; $display("FAIL reset_hi: got %h want 0", E_MD_Result);
    end
    @(negedge clk);
    reset = 1'b1;
    read_hilo(hi, lo);
    vectors++;
    if (lo !== 32'd0) begin
      miscompares++; $display("FAIL reset_lo: got %h want 0", lo);
    end
  endtask

  task automatic test_mult;
    logic [31:0] hi, lo;
    drive(1'b1, 4'd1, 32'hFFFF_FFFD, 32'd5);
    vectors++;
    if (E_Start !== 1'b1) begin
      miscompares++; $display("FAIL mult_start: got %b want 1", E_Start);
    end
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 4'd0, 32'd0, 32'd0);
      vectors++;
      if (E_Busy !== 1'b1) begin
        miscompares++; $display("FAIL mult_busy_t%0d: got %b want 1", i, E_Busy);
      end
    end
    drive(1'b1, 4'd0, 32'd0, 32'd0);
    vectors++;
    if (E_Busy !== 1'b0) begin
      miscompares++; $display("FAIL mult_idle_t6: got %b want 0", E_Busy);
    end
    read_hilo(hi, lo);
    vectors++;
    if (lo !== 32'hFFFF_FFF1) begin
      miscompares++; $display("FAIL mult_lo: got %h want fffffff1", lo);
    end
    vectors++;
    if (hi !== 32'hFFFF_FFFF) begin
      miscompares++; $display("FAIL mult_hi: got %h want ffffffff", hi);
    end
  endtask

  task automatic test_back_to_back_div;
    logic [31:0] hi, lo;
    drive(1'b1, 4'd4, 32'd7, 32'd2);
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 4'd0, 32'd0, 32'd0);
      vectors++;
      if (E_Busy !== 1'b1) begin
        miscompares++; $display("FAIL divu_busy_t%0d: got %b want 1", i, E_Busy);
      end
    end
    // First idle cycle: the next start must be accepted here.
    drive(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2);
    vectors++;
    if (E_Start !== 1'b1 || E_Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_start: got start=%b busy=%b want start=1 busy=0", E_Start, E_Busy);
    end
    for (int i = 1; i <= 10; i++) drive(1'b1, 4'd0, 32'd0, 32'd0);
    read_hilo(hi, lo);
    vectors++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL div_neg: got hi=%h lo=%h want hi=ffffffff lo=fffffffd", hi, lo);
    end
    // divu 7/2 alone, to check the first result independently.
    drive(1'b1, 4'd4, 32'd7, 32'd2);
    for (int i = 1; i <= 10; i++) drive(1'b1, 4'd0, 32'd0, 32'd0);
    read_hilo(hi, lo);
    vectors++;
    if (lo !== 32'd3 || hi !== 32'd1) begin
      miscompares++; $display("FAIL divu_7_2: got hi=%h lo=%h want hi=1 lo=3", hi, lo);
    end
    drive(1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 1; i <= 10; i++) drive(1'b1, 4'd0, 32'd0, 32'd0);
    read_hilo(hi, lo);
    vectors++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
      miscompares++; $display("FAIL div_ovf: got hi=%h lo=%h want hi=0 lo=80000000", hi, lo);
    end
  endtask

  task automatic test_mthi_mfhi;
    drive(1'b1, 4'd5, 32'h1234_5678, 32'd0);
    vectors++;
    if (E_Start !== 1'b0) begin
      miscompares++; $display("FAIL mthi_start: got %b want 0", E_Start);
    end
    drive(1'b1, 4'd7, 32'd0, 32'd0);
    vectors++;
    if (E_MD_Result !== 32'h1234_5678 || E_Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mfhi_after_mthi: got %h busy=%b want 12345678 busy=0", E_MD_Result, E_Busy);
    end
    drive(1'b1, 4'd6, 32'hCAFE_F00D, 32'd0);
    drive(1'b1, 4'd8, 32'd0, 32'd0);
    vectors++;
    if (E_MD_Result !== 32'hCAFE_F00D) begin
      miscompares++; $display("FAIL mflo_after_mtlo: got %h want cafef00d", E_MD_Result);
    end
  endtask

  task automatic test_hazard;
    logic [31:0] hi, lo;
    D_Is_MD = 1'b1;
    drive(1'b1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    vectors++;
    if (MD_Stall !== 1'b1) begin
      miscompares++; $display("FAIL stall_start: got %b want 1", MD_Stall);
    end
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 4'd0, 32'd0, 32'd0);
      vectors++;
      if (MD_Stall !== 1'b1) begin
        miscompares++; $display("FAIL stall_busy_t%0d: got %b want 1", i, MD_Stall);
      end
    end
    drive(1'b1, 4'd0, 32'd0, 32'd0);
    vectors++;
    if (MD_Stall !== 1'b0) begin
      miscompares++; $display("FAIL stall_t6: got %b want 0", MD_Stall);
    end
    D_Is_MD = 1'b0;
    read_hilo(hi, lo);
    vectors++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      miscompares++;
      $display("FAIL multu_max: got hi=%h lo=%h want hi=fffffffe lo=00000001", hi, lo);
    end
  endtask

  task automatic test_div_by_zero;
    logic [31:0] hi, lo;
    drive(1'b1, 4'd5, 32'h0000_AAAA, 32'd0);
    drive(1'b1, 4'd6, 32'h0000_5555, 32'd0);
    drive(1'b1, 4'd3, 32'd100, 32'd0);
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 4'd0, 32'd0, 32'd0);
      vectors++;
      if (E_Busy !== 1'b1) begin
        miscompares++; $display("FAIL div0_busy_t%0d: got %b want 1", i, E_Busy);
      end
    end
    read_hilo(hi, lo);
    vectors++;
    if (hi !== 32'h0000_AAAA || lo !== 32'h0000_5555) begin
      miscompares++; $display("FAIL div0_keep: got hi=%h lo=%h want hi=aaaa lo=5555", hi, lo);
    end
  endtask

  task automatic test_bubble;
    logic [31:0] hi, lo;
    drive(1'b0, 4'd1, 32'd3, 32'd3);
    vectors++;
    if (E_Start !== 1'b0) begin
      miscompares++; $display("FAIL bubble_start: got %b want 0", E_Start);
    end
    drive(1'b0, 4'd5, 32'hDEAD_BEEF, 32'd0);
    vectors++;
    if (E_Busy !== 1'b0) begin
      miscompares++; $display("FAIL bubble_busy: got %b want 0", E_Busy);
    end
    read_hilo(hi, lo);
    vectors++;
    if (hi !== 32'h0000_AAAA || lo !== 32'h0000_5555) begin
      miscompares++; $display("FAIL bubble_keep: got hi=%h lo=%h want hi=aaaa lo=5555", hi, lo);
    end
  endtask

  task automatic test_reset_mid_div;
    logic [31:0] hi, lo;
    drive(1'b1, 4'd4, 32'd100, 32'd7);
    for (int i = 1; i <= 3; i++) drive(1'b1, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    E_MD_Op = 4'd7;
    #1;
    vectors++;
    if (E_Busy !== 1'b0 || E_MD_Result !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got busy=%b hi=%h want busy=0 hi=0", E_Busy, E_MD_Result);
    end
    E_MD_Op = 4'd8;
    #1;
    vectors++;
    if (E_MD_Result !== 32'd0) begin
      miscompares++; $display("FAIL reset_mid_lo: got %h want 0", E_MD_Result);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 12; i++) drive(1'b1, 4'd0, 32'd0, 32'd0);
    read_hilo(hi, lo);
    vectors++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      miscompares++; $display("FAIL no_late_commit: got hi=%h lo=%h want 0/0", hi, lo);
    end
    drive(1'b1, 4'd1, 32'd6, 32'd7);
    for (int i = 1; i <= 5; i++) drive(1'b1, 4'd0, 32'd0, 32'd0);
    read_hilo(hi, lo);
    vectors++;
    if (hi !== 32'd0 || lo !== 32'd42) begin
      miscompares++; $display("FAIL mult_after_reset: got hi=%h lo=%h want hi=0 lo=2a", hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_back_to_back_div();
    test_mthi_mfhi();
    test_hazard();
    test_div_by_zero();
    test_bubble();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/e_mdu_ctrl.md
Name: e_mdu_ctrl

Overview:
- Multiply/divide unit with HI/LO registers and its busy sequencer, placed in the E stage beside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the D_E pipeline register.
- Counts out the fixed operation latency and commits the result to HI/LO when the count finishes.
- Generates the MD stall request consumed by the Delay hazard unit, so a later MD instruction is held in D while the unit is busy.

Parameters:
MUL_CYCLES, 5, busy cycles for mult/multu (≥1)
DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
E_Valid  in  1  E-stage slot holds a real instruction (0 = bubble)
E_MD_Op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none
E_SrcA  in  32  forwarded rs value (E_RD1_FW)
E_SrcB  in  32  forwarded rt value (E_RD2_FW)
D_Is_MD  in  1  D-stage instruction has E_MD_Op ≠ 0
E_MD_Result  out  32  HI for mfhi, LO for mflo, else 0
E_Busy  out  1  operation in progress
E_Start  out  1  combinational: E_Valid & op ∈ {1..4} & !E_Busy
MD_Stall  out  1  combinational: D_Is_MD & (E_Start | E_Busy)

Behaviour:
- Reset (async, reset=0):
  - HI, LO, cnt and the pending registers go to 0; E_Busy=0.
  - Outputs settle within the same cycle, with no clock edge.
  - Reset mid-operation abandons the operation; no HI/LO write.
- State: cnt [3:0]; E_Busy = (cnt ≠ 0). Idle when cnt=0, busy otherwise.
- Start (edge at end of cycle t, E_Start=1):
  - Full 64-bit result computed from E_SrcA/E_SrcB and latched into pend_hi/pend_lo.
  - cnt loads MUL_CYCLES for ops 1-2, DIV_CYCLES for ops 3-4.
- Busy: E_Busy=1 for cycles t+1 … t+N; cnt decrements by 1 every edge.
- Commit: on the edge where cnt=1, HI←pend_hi, LO←pend_lo, cnt←0.
  - New values are readable in cycle t+N+1 (E_Busy=0).
- mult: signed 32×32→64. multu: unsigned. HI = bits [63:32], LO = bits [31:0].
- div: signed. LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned. LO = quotient, HI = remainder.
- Divisor 0 (div/divu): the busy sequence runs normally; HI and LO keep their old values at commit.
- mthi/mtlo (E_Valid=1, idle): HI (or LO) ← E_SrcA at the end of the cycle; no busy period.
- mfhi/mflo: E_MD_Result is combinational from the current HI/LO.
  - A preceding mthi is visible in the next cycle.
  - A mthi and mfhi issued in the same cycle cannot occur: there is only one E instruction per cycle.
- Any MD op (1-8) arriving while E_Busy=1 is ignored (no start, no HI/LO write).
  - The Delay unit guarantees this never happens via MD_Stall. A bench assertion flags it.
- Back-to-back: a new start is accepted in cycle t+N+1, the first idle cycle.
- E_Valid=0: op ignored; E_Start=0; no register write.
- Non-MD instructions flow through the pipeline unaffected while busy; only MD instructions stall.

Test Plan:
1. Reset, then mult with SrcA=0xFFFFFFFD (−3), SrcB=5 at cycle t -> E_Busy high t+1..t+5; at t+6 mflo=0xFFFFFFF1, mfhi=0xFFFFFFFF.
2. divu 7/2, then div 0xFFFFFFF9 (−7)/2 -> first: LO=3, HI=1 after 10 busy cycles; second: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. mthi 0x12345678 followed by mfhi -> E_MD_Result=0x12345678 in the next cycle; E_Busy stays 0.
4. Hazard: multu 0xFFFFFFFF×0xFFFFFFFF with D_Is_MD=1 held -> MD_Stall=1 in start cycle and all 5 busy cycles, 0 at t+6; result HI=0xFFFFFFFE, LO=0x00000001.
5. div with SrcB=0 after HI/LO preset to 0xAAAA/0x5555 -> 10 busy cycles, then HI=0xAAAA, LO=0x5555 unchanged.
6. Reset pulsed low mid-div (cycle t+4) -> E_Busy=0 immediately, HI=LO=0, no later commit; new mult afterwards completes normally.
